gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised gshare conditional-branch direction predictor, successor to the datapath's fixed 32-entry, PC-indexed 2-bit BHT. Indexes a table of saturating counters with PC XOR global history, speculatively updates history at fetch, and repairs history on mispredict resolution. Sits beside the BTB in IF; resolution comes from the ID-stage branch compare. Adds a post-reset clear sweep that the old BHT lacks.

## Interface
- ENTRIES, 32: counter count; power of 2, ≥4; IDX_W = log2(ENTRIES)
- CTR_W, 2: counter width, 1..4
- GHR_W, 5: global history bits, 1..IDX_W
- PC_LSB, 2: lowest PC bit used for indexing
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- ready  out  1  table initialised; predictions and updates accepted
- lookup_valid  in  1  IF holds a conditional branch this cycle
- lookup_pc  in  32  PC of that branch
- pred_taken  out  1  predicted direction, combinational
- pred_idx  out  IDX_W  table index used, for IF/ID pipelining
- pred_ghr  out  GHR_W  GHR value before this lookup's speculative shift
- update_valid  in  1  ID resolved a conditional branch
- update_idx  in  IDX_W  pred_idx carried with that branch
- update_ghr  in  GHR_W  pred_ghr carried with that branch
- update_taken  in  1  actual direction
- update_mispredict  in  1  prediction was wrong
- ghr  out  GHR_W  current speculative global history

## Operation
- Index: lookup_pc[PC_LSB +: IDX_W] XOR zero-extended ghr.
- pred_taken = MSB of the indexed counter, gated by ready and lookup_valid; otherwise 0.
- Init value per counter: 2^(CTR_W-1) - 1 (weakly not-taken).
- States: INIT, RUN.
  - INIT: write init value to entry clr_ptr, clr_ptr++; ready=0; lookups and updates ignored; leave after entry ENTRIES-1 is written.
  - RUN: ready=1; normal operation. Only rst returns to INIT.
- Speculative history: in RUN, lookup_valid -> ghr <= {ghr[GHR_W-2:0], pred_taken} (GHR_W=1: ghr <= pred_taken).
- Counter update: in RUN, update_valid -> counter[update_idx] increments if taken, decrements if not, saturating at 0 and 2^CTR_W-1.
- Repair: update_valid && update_mispredict -> ghr <= {update_ghr[GHR_W-2:0], update_taken}.
- Simultaneous lookup and repair: repair wins; that cycle's speculative shift is discarded.
- Simultaneous lookup and update on the same index: lookup reads the pre-update value; no bypass.
- update_mispredict without update_valid: ignored.

## Timing
- Reset: ready=0, ghr=0, pred_taken=0, pred_ghr=0, clr_ptr=0, state INIT.
- First RUN cycle is ENTRIES cycles after the cycle rst deasserts; ready rises on that edge.
- Lookup: zero latency; pred_taken/pred_idx/pred_ghr valid the same cycle as lookup_valid.
- Counter write and ghr change are visible to lookups one cycle after the update/lookup edge.
- rst mid-INIT or mid-RUN: table contents are don't-care; sweep restarts from 0 and takes a full ENTRIES cycles.
- clr_ptr wraps at IDX_W bits; no extra cycle at wrap.

## Structure
- Shared package bpu_pkg: function ctr_init(CTR_W), saturating increment/decrement functions, IDX_W derivation. The BTB successor reuses these.
- One sub-module: bpu_ctr_table, with one combinational read port, one write port, and a clear port driven by the sweep. Storage is a plain reg array, not reset.
- Top level holds the FSM, clr_ptr, ghr, index hash, and the update/repair priority.

## Test plan
- Init: assert rst 1 cycle, ENTRIES=32 -> ready rises exactly 32 cycles later; every counter reads 1 (CTR_W=2); pred_taken=0 throughout.
- Saturation: 4 taken updates at idx 5 -> counter 3, pred_taken=1; 5 not-taken updates -> counter 0, no underflow.
- History: pc=0x50, ghr=0 -> idx 20. After lookup predicting 1 -> ghr=00001. Next lookup of pc=0x50 -> idx 21.
- Repair: ghr=10110, update_mispredict with update_ghr=00011, taken=1 -> ghr=00111 next cycle.
- Same cycle, lookup plus mispredict -> ghr takes the repair value only. Lookup and update on the same idx -> pred_taken reflects the old counter.
- rst asserted at sweep cycle 10 -> ready stays 0 for a further 32 cycles after rst drops; updates during INIT leave no trace.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-prediction helpers: FSM state type, counter init value and
// saturating counter arithmetic, reused by the gshare predictor and the BTB.
package bpu_pkg;

    typedef enum logic {
        INIT,
        RUN
    } bpu_state_t;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Weakly not-taken: one step below the taken threshold.
    function automatic logic [3:0] ctr_init(input int ctr_w);
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] ctr_inc(input logic [3:0] value, input int ctr_w);
        return (int'(value) >= ((1 << ctr_w) - 1)) ? value : value + 4'd1;
    endfunction

    function automatic logic [3:0] ctr_dec(input logic [3:0] value);
        return (value == 4'd0) ? value : value - 4'd1;
    endfunction

endpackage

// File: rtl/bpu_ctr_table.sv
// Saturating-counter table: one combinational read port, one read-modify-write
// update port, and a clear port used by the post-reset sweep. Storage is not reset.
module bpu_ctr_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int CTR_W = 2,
    localparam int IDX_W = idx_width(ENTRIES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic [CTR_W-1:0] mem [ENTRIES];
    logic [CTR_W-1:0] wr_cur;
    logic [CTR_W-1:0] wr_next;

    assign rd_data = mem[rd_idx];
    assign wr_cur  = mem[wr_idx];
    assign wr_next = wr_taken ? CTR_W'(ctr_inc(4'(wr_cur), CTR_W))
                              : CTR_W'(ctr_dec(4'(wr_cur)));

    // The sweep owns the table while it runs; updates are only enabled afterwards.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= CTR_W'(ctr_init(CTR_W));
        end else if (wr_en) begin
            mem[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC XOR global history indexes a counter table;
// history is shifted speculatively at lookup and repaired on a mispredict.
module gshare_predictor
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int CTR_W = 2,
    parameter int GHR_W = 5,
    parameter int PC_LSB = 2,
    localparam int IDX_W = idx_width(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_idx,
    input  logic [GHR_W-1:0] update_ghr,
    input  logic             update_taken,
    input  logic             update_mispredict,
    output logic [GHR_W-1:0] ghr
);

    bpu_state_t       state;
    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] lookup_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] repair_ghr;
    logic             unused_bits;

    assign lookup_idx = lookup_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr);
    assign pred_idx   = lookup_idx;
    assign pred_ghr   = ghr;
    assign pred_taken = ready & lookup_valid & rd_ctr[CTR_W-1];

    // Only a window of the PC and the low history bits feed the logic.
    assign unused_bits = &{1'b0, lookup_pc, update_ghr, 1'b0};

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign spec_ghr   = pred_taken;
            assign repair_ghr = update_taken;
        end else begin : g_ghr_wide
            assign spec_ghr   = {ghr[GHR_W-2:0], pred_taken};
            assign repair_ghr = {update_ghr[GHR_W-2:0], update_taken};
        end
    endgenerate

    bpu_ctr_table #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W)
    ) u_table (
        .clk      (clk),
        .rd_idx   (lookup_idx),
        .rd_data  (rd_ctr),
        .wr_en    (ready & update_valid),
        .wr_idx   (update_idx),
        .wr_taken (update_taken),
        .clr_en   ((state == INIT) & ~rst),
        .clr_idx  (clr_ptr)
    );

    // Repair outranks the same cycle's speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_ptr <= '0;
            ready   <= 1'b0;
            ghr     <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + IDX_W'(1);
                    if (clr_ptr == IDX_W'(ENTRIES - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (update_valid && update_mispredict) begin
                        ghr <= repair_ghr;
                    end else if (lookup_valid) begin
                        ghr <= spec_ghr;
                    end
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (32 entries, 2-bit counters, 5-bit history)
// with a cycle-level reference model and per-cycle output comparison.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [4:0]  pred_idx;
    logic [4:0]  pred_ghr;
    logic        update_valid = 1'b0;
    logic [4:0]  update_idx = '0;
    logic [4:0]  update_ghr = '0;
    logic        update_taken = 1'b0;
    logic        update_mispredict = 1'b0;
    logic [4:0]  ghr;

    int checks_total = 0;
    int checks_passed = 0;

    int m_ctr [32];
    int m_ghr = 0;
    bit m_ready = 1'b0;
    int m_sweep = 0;
    bit m_started = 1'b0;

    gshare_predictor #(
        .ENTRIES (32),
        .CTR_W   (2),
        .GHR_W   (5),
        .PC_LSB  (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ready             (ready),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_taken        (pred_taken),
        .pred_idx          (pred_idx),
        .pred_ghr          (pred_ghr),
        .update_valid      (update_valid),
        .update_idx        (update_idx),
        .update_ghr        (update_ghr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .ghr               (ghr)
    );

    always #5 clk = ~clk;

    function automatic int modelIndex(input logic [31:0] pc);
        return ((int'(pc) >>> 2) & 31) ^ m_ghr;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then settle.
    task automatic applyStimulus(input logic lv, input logic [31:0] pc, input logic uv,
                                 input logic [4:0] uidx, input logic [4:0] ughr,
                                 input logic ut, input logic um);
        @(posedge clk);
        #2;
        lookup_valid      = lv;
        lookup_pc         = pc;
        update_valid      = uv;
        update_idx        = uidx;
        update_ghr        = ughr;
        update_taken      = ut;
        update_mispredict = um;
        #2;
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #2;
        rst = 1'b1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        update_mispredict = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #2;
    endtask

    // Reference model: ready after 32 clean cycles, all counters weakly not-taken,
    // then saturating 0..3 counters and a 5-bit history with repair priority.
    always @(posedge clk) begin
        int pred;
        int li;
        if (rst) begin
            m_started = 1'b1;
            m_ready   = 1'b0;
            m_sweep   = 0;
            m_ghr     = 0;
        end else if (m_started) begin
            if (!m_ready) begin
                m_sweep++;
                if (m_sweep == 32) begin
                    m_ready = 1'b1;
                    foreach (m_ctr[i]) m_ctr[i] = 1;
                end
            end else begin
                li = modelIndex(lookup_pc);
                pred = (lookup_valid && m_ctr[li] >= 2) ? 1 : 0;
                if (update_valid) begin
                    if (update_taken) m_ctr[update_idx] = (m_ctr[update_idx] >= 3) ? 3 : m_ctr[update_idx] + 1;
                    else              m_ctr[update_idx] = (m_ctr[update_idx] <= 0) ? 0 : m_ctr[update_idx] - 1;
                end
                if (update_valid && update_mispredict)
                    m_ghr = (int'(update_ghr) * 2 + int'(update_taken)) % 32;
                else if (lookup_valid)
                    m_ghr = (m_ghr * 2 + pred) % 32;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("ready", 32'(ready), 32'(m_ready));
            checkOutput("ghr", 32'(ghr), 32'(m_ghr));
            checkOutput("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
            if (lookup_valid) begin
                checkOutput("pred_idx", 32'(pred_idx), 32'(modelIndex(lookup_pc)));
                checkOutput("pred_taken", 32'(pred_taken),
                            (m_ready && m_ctr[modelIndex(lookup_pc)] >= 2) ? 32'd1 : 32'd0);
            end else begin
                checkOutput("pred_taken_idle", 32'(pred_taken), 32'd0);
            end
        end
    end

    initial begin
        @(posedge clk);
        #2;
        rst = 1'b0;
        #2;
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_ghr", 32'(ghr), 32'd0);
        checkOutput("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        checkOutput("rst_pred_taken", 32'(pred_taken), 32'd0);

        // Sweep: lookups and mispredict updates are ignored until ready.
        for (int i = 1; i <= 31; i++) begin
            applyStimulus(1'b1, 32'hABCD_0003 | (i << 2), 1'b1, 5'(i), 5'd0, 1'b1, 1'b1);
            checkOutput("init_ready_low", 32'(ready), 32'd0);
            checkOutput("init_pred_taken", 32'(pred_taken), 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("init_ready_rise", 32'(ready), 32'd1);
        checkOutput("init_ghr_untouched", 32'(ghr), 32'd0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 | (i << 2), 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            checkOutput("sweep_idx", 32'(pred_idx), 32'(i));
            checkOutput("sweep_weak_nt", 32'(pred_taken), 32'd0);
        end

        // Saturation at index 5.
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_hi_idx", 32'(pred_idx), 32'd5);
        checkOutput("sat_hi_taken", 32'(pred_taken), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1);
        checkOutput("sat_spec_shift", 32'(ghr), 32'd1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h14, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_lo_ghr", 32'(ghr), 32'd0);
        checkOutput("sat_lo_taken", 32'(pred_taken), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_lo_plus1", 32'(pred_taken), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_lo_plus2", 32'(pred_taken), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1);

        // History: pc 0x50 indexes 20, then 21 after a taken prediction.
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 5'd20, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h50, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("hist_idx0", 32'(pred_idx), 32'd20);
        checkOutput("hist_taken0", 32'(pred_taken), 32'd1);
        checkOutput("hist_pred_ghr0", 32'(pred_ghr), 32'd0);
        applyStimulus(1'b1, 32'h50, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("hist_ghr1", 32'(ghr), 32'b00001);
        checkOutput("hist_idx1", 32'(pred_idx), 32'd21);
        checkOutput("hist_taken1", 32'(pred_taken), 32'd0);

        // Repair from a known history.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd9, 5'b01011, 1'b0, 1'b1);
        checkOutput("rep_pre", 32'(ghr), 32'b00010);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd9, 5'b00011, 1'b1, 1'b1);
        checkOutput("rep_setup", 32'(ghr), 32'b10110);
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("rep_result", 32'(ghr), 32'b00111);

        // Lookup and mispredict together: repair value only.
        applyStimulus(1'b1, 32'h50, 1'b1, 5'd19, 5'b10000, 1'b1, 1'b1);
        checkOutput("both_idx", 32'(pred_idx), 32'd19);
        checkOutput("both_taken", 32'(pred_taken), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("both_ghr", 32'(ghr), 32'b00001);

        // Lookup and update on one index: lookup sees the old counter.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd21, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h50, 1'b1, 5'd21, 5'd0, 1'b0, 1'b0);
        checkOutput("same_idx", 32'(pred_idx), 32'd21);
        checkOutput("same_old_value", 32'(pred_taken), 32'd1);
        applyStimulus(1'b1, 32'h58, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("same_ghr", 32'(ghr), 32'b00011);
        checkOutput("same_after_idx", 32'(pred_idx), 32'd21);
        checkOutput("same_after_value", 32'(pred_taken), 32'd0);

        // Reset in the middle of a sweep restarts the full 32-cycle clear.
        resetPulse();
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            checkOutput("rs1_ready_low", 32'(ready), 32'd0);
        end
        resetPulse();
        for (int i = 1; i <= 31; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0);
            checkOutput("rs2_ready_low", 32'(ready), 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("rs2_ready_rise", 32'(ready), 32'd1);
        applyStimulus(1'b1, 32'h0C, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("rs2_idx", 32'(pred_idx), 32'd3);
        checkOutput("rs2_no_trace", 32'(pred_taken), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
